mult_div_unit: RTL and testbench

Sequential multiply/divide unit for the multicycle MIPS datapath, consuming the A and B operand register outputs (SaidaA/SaidaB). It executes MULT, MULTU, DIV and DIVU one bit per cycle and holds the 64-bit result in internal HI/LO registers. It uses a Start/Busy/Done handshake, and the control FSM stalls on Busy. HI/LO feed the write-back mux for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 170 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential MULT/MULTU/DIV/DIVU unit for the multicycle MIPS
// datapath. One iteration per clock; the 64-bit result lands in HI/LO.
// Ports:
//   Clk     - clock, rising edge
//   Reset   - synchronous active-high reset, aborts any operation
//   Start   - operation request, honoured only while idle
//   Op      - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with Start)
//   A, B    - operands rs / rt
//   Hi, Lo  - HI/LO registers (product high/low, or remainder/quotient)
//   Busy    - operation in progress
//   Done    - one-cycle pulse when Hi/Lo update or a divide-by-zero ends
//   DivZero - divide with B==0; held until the next accepted Start
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               divz_q;      // pending divide-by-zero, skips CALC
  logic               sa_q, sb_q;  // operand sign flags (0 for unsigned ops)
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, done_q, divzero_q;

  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     shifted_s, addend_s, sum_s;
  logic               ge_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, remd_s;

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;

  // Operand magnitudes and sign flags at acceptance; Op[0]=1 means unsigned.
  always_comb begin
    a_neg_s = ~Op[0] & A[WIDTH-1];
    b_neg_s = ~Op[0] & B[WIDTH-1];
    a_mag_s = a_neg_s ? (-A) : A;
    b_mag_s = b_neg_s ? (-B) : B;
  end

  // One CALC iteration. Multiply: acc = {product high, multiplier being shifted
  // out}. Divide: acc low half holds dividend bits shifting out / quotient bits
  // shifting in, and the trial remainder is WIDTH+1 bits wide.
  always_comb begin
    shifted_s = {rem_q, acc_q[WIDTH-1]};
    // A set top bit means the trial value already exceeds any WIDTH-bit divisor.
    ge_s      = shifted_s[WIDTH] | (shifted_s[WIDTH-1:0] >= opb_q);
    addend_s  = acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}};
    sum_s     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend_s;
    if (is_div_q) begin
      acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge_s};
      rem_d = ge_s ? (shifted_s[WIDTH-1:0] - opb_q) : shifted_s[WIDTH-1:0];
    end else begin
      acc_d = {sum_s, acc_q[WIDTH-1:1]};
      rem_d = rem_q;
    end
  end

  // Sign correction applied in FINISH; remainder follows the dividend sign.
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? (-acc_q) : acc_q;
    quot_s = (sa_q ^ sb_q) ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    remd_s = sa_q ? (-rem_q) : rem_q;
    if (is_div_q) begin
      hi_d = remd_s;
      lo_d = quot_s;
    end else begin
      hi_d = prod_s[2*WIDTH-1:WIDTH];
      lo_d = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM with all state and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      is_div_q  <= 1'b0;
      divz_q    <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      opa_q     <= {WIDTH{1'b0}};
      opb_q     <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            divzero_q <= 1'b0;
            is_div_q  <= Op[1];
            sa_q      <= a_neg_s;
            sb_q      <= b_neg_s;
            opa_q     <= a_mag_s;
            opb_q     <= b_mag_s;
            cnt_q     <= CW'(WIDTH);
            acc_q     <= {{WIDTH{1'b0}}, (Op[1] ? a_mag_s : b_mag_s)};
            rem_q     <= {WIDTH{1'b0}};
            busy_q    <= 1'b1;
            if (Op[1] && (B == {WIDTH{1'b0}})) begin
              divz_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              divz_q  <= 1'b0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
          if (divz_q) begin
            divzero_q <= 1'b1;
          end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected Hi/Lo/DivZero,
// a negedge monitor pops and compares on every Done pulse.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, DivZero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT against the scoreboard on each Done pulse.
  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Done === 1'b1) begin
      chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {63'd0, Done}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("hi", {32'd0, Hi}, {32'd0, e.hi});
        chk("lo", {32'd0, Lo}, {32'd0, e.lo});
        chk("divzero_with_done", {63'd0, DivZero}, {63'd0, e.dz});
      end
    end
    prev_done = Done;
  end

  // Called mid-cycle (negedge): Start is raised in cycle 0, then Busy/Done are
  // checked cycle by cycle until the Done cycle 'lat'. At cycle 'inj' a stray
  // Start is pulsed while busy.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz,
                       input int lat, input int inj);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz;
    exp_q.push_back(e);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge Clk);
      chk("busy", {63'd0, Busy}, {63'd0, (c < lat)});
      chk("done_timing", {63'd0, Done}, {63'd0, (c == lat)});
      if (c < lat) chk("divzero_cleared", {63'd0, DivZero}, 64'd0);
      if (c == inj) begin
        Start = 1'b1; Op = 2'b01; A = 32'd1; B = 32'd1;
      end else begin
        Start = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_divzero", {63'd0, DivZero}, 64'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // MULTU, MULT, signed corner cases, DIV/DIVU; back-to-back starts land in
    // the previous op's Done cycle.
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, -1);
    do_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, -1);
    do_op(2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0, 34, -1);
    do_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, -1);
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, -1);
    do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, -1);

    // Divide by zero: short path, Hi/Lo untouched, DivZero sticky.
    do_op(2'b11, 32'd5, 32'd0, 32'd2, 32'd14, 1'b1, 2, -1);
    repeat (3) @(negedge Clk);
    chk("divzero_sticky", {63'd0, DivZero}, 64'd1);
    chk("hilo_hold", {Hi, Lo}, {32'd2, 32'd14});

    // DIV overflow with a stray Start during Busy.
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 5);
    repeat (40) @(negedge Clk);

    // Reset in cycle 10 aborts a MULTU; no Done may follow.
    Op = 2'b01; A = 32'd6; B = 32'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_done", {63'd0, Done}, 64'd0);
    chk("abort_hilo", {Hi, Lo}, 64'd0);
    repeat (40) @(negedge Clk);
    do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34, -1);

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
